result_checker: RTL
===================

// Module: result_checker
// PURPOSE
//  Hardware result reader/checker: the reader side of the output SRAM the accelerator writes.
//  On a chk_run/chk_busy handshake (same protocol as dut_run/dut_busy) it streams N words from
//  the result SRAM and a golden SRAM, compares them word-by-word and reports match statistics.
//  Sits beside MyDesign on the output SRAM read port; lets on-chip/FPGA runs self-check without a host.
// PARAMETERS
//  ADDR_WIDTH  12              SRAM address width
//  DATA_WIDTH  16              SRAM data width
//  CNT_WIDTH   ADDR_WIDTH+1    width of word count / statistics counters
// PORTS
//  clk                    in   1           single clock, all logic on posedge
//  reset_b                in   1           synchronous, active-low reset
//  chk_run                in   1           start request (level, handshake with chk_busy)
//  chk_busy               out  1           high while a check is in progress
//  cfg_base_addr          in   ADDR_WIDTH  result SRAM start address, sampled at start
//  cfg_num_words          in   CNT_WIDTH   words to check, sampled at start
//  chk_res_read_address   out  ADDR_WIDTH  result SRAM read address
//  res_chk_read_data      in   DATA_WIDTH  result SRAM read data (valid 1 cycle after address)
//  chk_gold_read_address  out  ADDR_WIDTH  golden SRAM read address (index from 0)
//  gold_chk_read_data     in   DATA_WIDTH  golden SRAM read data (valid 1 cycle after address)
//  chk_match_count        out  CNT_WIDTH   words equal
//  chk_mismatch_count     out  CNT_WIDTH   words differing
//  chk_first_err_addr     out  ADDR_WIDTH  result address of first mismatch
//  chk_first_err_valid    out  1           chk_first_err_addr is meaningful
//  chk_pass               out  1           done, N>0, mismatch_count==0
// BEHAVIOUR
//  - Reset (reset_b==0 at posedge): state IDLE, all outputs 0, armed=0. Mid-run reset aborts at once.
//  - armed sets when chk_run sampled 0; start requires IDLE & armed & chk_run==1 (no re-run on held run).
//  - Start edge T: latch base/N, clear counts/err/pass, armed=0; chk_busy=1 from T+1.
//  - FSM: IDLE -> ISSUE (N cycles, idx 0..N-1; res addr=base+idx mod 2^ADDR_WIDTH, gold addr=idx)
//    -> DRAIN (1 cycle, last compare) -> IDLE. N==0: IDLE -> DRAIN -> IDLE, counts 0, pass 0.
//  - Compare stage 1 cycle behind issue: valid_d registered with idx_d; on valid_d compare full words,
//    increment match or mismatch; first mismatch latches base+idx_d and sets first_err_valid.
//  - chk_busy high exactly N+1 cycles; all results final and stable when chk_busy falls; held until next start.
//  - chk_pass updated on DRAIN->IDLE only. Counters never saturate (CNT_WIDTH covers 2^ADDR_WIDTH words).
//  - Addresses hold last value in IDLE. chk_run changes while busy are ignored.
// CONFIGURATION
//  CHK_STOP_ON_MISMATCH_EN defined: on first mismatch compare, ISSUE aborts; next cycle is DRAIN
//    (one in-flight word compared and counted normally), then IDLE; pass=0.
//  Not defined: all N words always checked; busy length always N+1.
// STRUCTURE
//  Package result_checker_pkg: chk_state_e {CHK_IDLE, CHK_ISSUE, CHK_DRAIN}, width localparams.
//  Sub-module result_cmp_acc: compare/accumulate stage (valid_d, data pair -> counters, first-error latch).
//  Top holds FSM, arming, address generation.
// TESTING
//  1 N=1, base 0, data equal -> busy high 2 cycles, match=1, mismatch=0, pass=1.
//  2 N=32, base 12'h040, word idx5 differs -> match=31, mismatch=1, first_err_addr=12'h045, valid=1, pass=0.
//  3 N=0 -> busy high 1 cycle, all counts 0, pass=0.
//  4 chk_run held 1 through completion -> no restart; drop 1 cycle then raise -> new run starts.
//  5 reset_b=0 during ISSUE at idx 10 of 32 -> next cycle busy=0, all outputs 0, FSM IDLE.
//  6 base=12'hFFE, N=4 -> res addrs FFE,FFF,000,001; with CHK_STOP_ON_MISMATCH_EN, mismatch at idx1
//    of 8 -> busy falls early, match+mismatch<=3, first_err_addr=12'hFFF.

Source files
------------

// File: rtl/result_checker_pkg.sv
// Shared types and default widths for the result checker.
package result_checker_pkg;

  localparam int CHK_ADDR_W = 12;
  localparam int CHK_DATA_W = 16;
  localparam int CHK_CNT_W  = CHK_ADDR_W + 1;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_ISSUE,
    CHK_DRAIN
  } chk_state_e;

endpackage

// File: rtl/result_cmp_acc.sv
// Compare/accumulate stage: runs one cycle behind address issue, counts matches and
// mismatches, and latches the result address of the first mismatch.
module result_cmp_acc
  import result_checker_pkg::*;
#(
  parameter int ADDR_WIDTH = CHK_ADDR_W,
  parameter int DATA_WIDTH = CHK_DATA_W,
  parameter int CNT_WIDTH  = CHK_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  i_clear,
  input  logic                  i_issue_vld,
  input  logic [ADDR_WIDTH-1:0] i_issue_idx,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  input  logic [DATA_WIDTH-1:0] i_gold_data,
  output logic                  o_mis_hit,
  output logic [CNT_WIDTH-1:0]  o_match_count,
  output logic [CNT_WIDTH-1:0]  o_mismatch_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic                  o_first_err_valid
);

  logic                  r_vld_d;
  logic [ADDR_WIDTH-1:0] r_idx_d;
  logic [CNT_WIDTH-1:0]  r_match;
  logic [CNT_WIDTH-1:0]  r_mismatch;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  r_err_vld;
  logic [ADDR_WIDTH-1:0] w_cur_addr;

  assign w_cur_addr = i_base + r_idx_d;
  assign o_mis_hit  = r_vld_d && (i_res_data != i_gold_data);

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_vld_d    <= 1'b0;
      r_idx_d    <= '0;
      r_match    <= '0;
      r_mismatch <= '0;
      r_err_addr <= '0;
      r_err_vld  <= 1'b0;
    end else begin
      r_vld_d <= i_issue_vld;
      r_idx_d <= i_issue_idx;
      if (i_clear) begin
        r_match    <= '0;
        r_mismatch <= '0;
        r_err_addr <= '0;
        r_err_vld  <= 1'b0;
      end else if (r_vld_d) begin
        if (o_mis_hit) begin
          r_mismatch <= r_mismatch + 1'b1;
          if (!r_err_vld) begin
            r_err_addr <= w_cur_addr;
            r_err_vld  <= 1'b1;
          end
        end else begin
          r_match <= r_match + 1'b1;
        end
      end
    end
  end

  assign o_match_count     = r_match;
  assign o_mismatch_count  = r_mismatch;
  assign o_first_err_addr  = r_err_addr;
  assign o_first_err_valid = r_err_vld;

endmodule

// File: rtl/result_checker.sv
// Result SRAM reader/checker: run/busy handshake, address issue FSM and arming.
// Optional CHK_STOP_ON_MISMATCH_EN: abort issue on the first mismatch, drain one word, finish.
module result_checker
  import result_checker_pkg::*;
#(
  parameter int ADDR_WIDTH = CHK_ADDR_W,
  parameter int DATA_WIDTH = CHK_DATA_W,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  chk_run,
  output logic                  chk_busy,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  output logic [ADDR_WIDTH-1:0] chk_res_read_address,
  input  logic [DATA_WIDTH-1:0] res_chk_read_data,
  output logic [ADDR_WIDTH-1:0] chk_gold_read_address,
  input  logic [DATA_WIDTH-1:0] gold_chk_read_data,
  output logic [CNT_WIDTH-1:0]  chk_match_count,
  output logic [CNT_WIDTH-1:0]  chk_mismatch_count,
  output logic [ADDR_WIDTH-1:0] chk_first_err_addr,
  output logic                  chk_first_err_valid,
  output logic                  chk_pass
);

  chk_state_e            r_state;
  logic                  r_busy, r_armed, r_pass;
  logic [ADDR_WIDTH-1:0] r_base, r_res_addr, r_gold_addr;
  logic [CNT_WIDTH-1:0]  r_num, r_idx;
  logic                  w_start, w_issue, w_last_issue, w_abort, w_mis_hit;
  logic [CNT_WIDTH-1:0]  w_mis_cnt;

  assign w_start      = (r_state == CHK_IDLE) && r_armed && chk_run;
  assign w_issue      = (r_state == CHK_ISSUE);
  assign w_last_issue = (r_idx == r_num - 1'b1);
`ifdef CHK_STOP_ON_MISMATCH_EN
  assign w_abort = w_mis_hit;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state     <= CHK_IDLE;
      r_busy      <= 1'b0;
      r_armed     <= 1'b0;
      r_pass      <= 1'b0;
      r_base      <= '0;
      r_num       <= '0;
      r_idx       <= '0;
      r_res_addr  <= '0;
      r_gold_addr <= '0;
    end else begin
      case (r_state)
        CHK_IDLE: begin
          // Arming on a sampled low level blocks re-runs while chk_run stays high.
          if (!chk_run) r_armed <= 1'b1;
          if (w_start) begin
            r_base      <= cfg_base_addr;
            r_num       <= cfg_num_words;
            r_idx       <= '0;
            r_res_addr  <= cfg_base_addr;
            r_gold_addr <= '0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_state     <= (cfg_num_words == '0) ? CHK_DRAIN : CHK_ISSUE;
          end
        end
        CHK_ISSUE: begin
          if (w_last_issue || w_abort) begin
            r_state <= CHK_DRAIN;
          end else begin
            r_idx       <= r_idx + 1'b1;
            r_res_addr  <= r_res_addr + 1'b1;
            r_gold_addr <= r_gold_addr + 1'b1;
          end
        end
        CHK_DRAIN: begin
          // Last compare lands on this edge, so fold it into the pass decision.
          r_state <= CHK_IDLE;
          r_busy  <= 1'b0;
          r_pass  <= (r_num != '0) && (w_mis_cnt == '0) && !w_mis_hit;
        end
        default: r_state <= CHK_IDLE;
      endcase
    end
  end

  result_cmp_acc #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cmp (
    .clk              (clk),
    .reset_b          (reset_b),
    .i_clear          (w_start),
    .i_issue_vld      (w_issue),
    .i_issue_idx      (r_idx[ADDR_WIDTH-1:0]),
    .i_base           (r_base),
    .i_res_data       (res_chk_read_data),
    .i_gold_data      (gold_chk_read_data),
    .o_mis_hit        (w_mis_hit),
    .o_match_count    (chk_match_count),
    .o_mismatch_count (w_mis_cnt),
    .o_first_err_addr (chk_first_err_addr),
    .o_first_err_valid(chk_first_err_valid)
  );

  assign chk_mismatch_count    = w_mis_cnt;
  assign chk_busy              = r_busy;
  assign chk_pass              = r_pass;
  assign chk_res_read_address  = r_res_addr;
  assign chk_gold_read_address = r_gold_addr;

endmodule
